// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two ALU requesters and alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_op1;
  logic [DATA_WIDTH-1:0] req0_op2;
  logic [2:0]            req0_ctrl;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_op1;
  logic [DATA_WIDTH-1:0] req1_op2;
  logic [2:0]            req1_ctrl;

  logic                  resp0_valid;
  logic                  resp0_ready;
  logic                  resp1_valid;
  logic                  resp1_ready;
  logic [DATA_WIDTH-1:0] resp_out;
  logic                  resp_eq;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_out, resp_eq,
    output resp0_ready, resp1_ready
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_out, resp_eq,
    input  resp0_ready, resp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: accept one op, execute, return result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted combinationally to the winner
// EXEC  | ALU driven from latched operands; result captured on the edge
// RESP  | result held on resp_out/resp_eq until the winner's resp_ready
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  winner;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [2:0]            ctrl_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  eq_q;
  logic                  resp0_valid_q;
  logic                  resp1_valid_q;
  logic                  grant0;
  logic                  grant1;
  logic                  winner_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant0 = bus.req0_valid;
`else
      // On a tie, the requester that was not granted last time wins.
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
`endif
      grant1 = bus.req1_valid && !grant0;
    end
  end

  assign winner_ready = winner ? bus.resp1_ready : bus.resp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      winner        <= 1'b0;
      last_grant    <= 1'b1;
      op1_q         <= '0;
      op2_q         <= '0;
      ctrl_q        <= '0;
      result_q      <= '0;
      eq_q          <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            winner     <= grant1;
            last_grant <= grant1;
            op1_q      <= grant1 ? bus.req1_op1  : bus.req0_op1;
            op2_q      <= grant1 ? bus.req1_op2  : bus.req0_op2;
            ctrl_q     <= grant1 ? bus.req1_ctrl : bus.req0_ctrl;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q      <= alu_out;
          eq_q          <= alu_eq;
          resp0_valid_q <= !winner;
          resp1_valid_q <= winner;
          state         <= RESP;
        end
        RESP: begin
          if (winner_ready) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp_out    = result_q;
  assign bus.resp_eq     = eq_q;

  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;
  assign alu_ctrl = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_eq;

  int n_pass;
  int n_total;

  logic [31:0] last_op1;
  logic [31:0] last_op2;
  logic [2:0]  last_ctrl;

  alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_eq   (alu_eq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {31'b0, $signed(a) < $signed(b)};
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Stand-in for the datapath ALU instance.
  always_comb begin
    alu_out = alu_ref(alu_op1, alu_op2, alu_ctrl);
    alu_eq  = (alu_op1 == alu_op2);
  end

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_op1    = '0;
    bus.req0_op2    = '0;
    bus.req0_ctrl   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_op1    = '0;
    bus.req1_op2    = '0;
    bus.req1_ctrl   = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    n_total++;
    if ({alu_op1, alu_op2, alu_ctrl} !== 67'd0)
      $display("FAIL reset_alu: got op1=%h op2=%h ctrl=%h expected 0", alu_op1, alu_op2, alu_ctrl);
    else n_pass++;
    n_total++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_eq} !== 3'b000 || bus.resp_out !== 32'd0)
      $display("FAIL reset_resp: got v0=%b v1=%b eq=%b out=%h expected 0",
               bus.resp0_valid, bus.resp1_valid, bus.resp_eq, bus.resp_out);
    else n_pass++;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_op1   = 32'd5;
    bus.req0_op2   = 32'd7;
    bus.req0_ctrl  = 3'b000;
    #1;
    n_total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL single_accept: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    else n_pass++;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_total++;
    if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_ctrl !== 3'd0 || bus.resp0_valid !== 1'b0)
      $display("FAIL single_exec: got op1=%0d op2=%0d ctrl=%0d v0=%b expected 5 7 0 0",
               alu_op1, alu_op2, alu_ctrl, bus.resp0_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp_out !== 32'd12 || bus.resp_eq !== 1'b0)
      $display("FAIL single_resp: got v0=%b v1=%b out=%0d eq=%b expected 1 0 12 0",
               bus.resp0_valid, bus.resp1_valid, bus.resp_out, bus.resp_eq);
    else n_pass++;
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    n_total++;
    if (bus.resp0_valid !== 1'b0)
      $display("FAIL single_done: got v0=%b expected 0", bus.resp0_valid);
    else n_pass++;
  endtask

  task automatic test_equality();
    @(negedge clk);
    bus.req1_valid = 1'b1;
    bus.req1_op1   = 32'hDEADBEEF;
    bus.req1_op2   = 32'hDEADBEEF;
    bus.req1_ctrl  = 3'b000;
    #1;
    n_total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      $display("FAIL eq_accept: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    else n_pass++;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp_out !== 32'hBD5B7DDE || bus.resp_eq !== 1'b1)
      $display("FAIL eq_resp: got v1=%b v0=%b out=%h eq=%b expected 1 0 bd5b7dde 1",
               bus.resp1_valid, bus.resp0_valid, bus.resp_out, bus.resp_eq);
    else n_pass++;
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_g [4];
    logic got;
    bit   seen;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid  = 1'b1; bus.req0_op1 = 32'd10; bus.req0_op2 = 32'd3; bus.req0_ctrl = 3'd1;
    bus.req1_valid  = 1'b1; bus.req1_op1 = 32'd4;  bus.req1_op2 = 32'd4; bus.req1_ctrl = 3'd2;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      got  = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (c != 0 || k != 0) begin
          @(negedge clk); #1;
        end
        if (bus.req0_ready || bus.req1_ready) begin
          seen = 1'b1;
          got  = bus.req1_ready;
        end
      end
      n_total++;
      if (!seen)
        $display("FAIL contention_grant%0d: got no grant within 10 cycles expected %0d", k, exp_g[k]);
      else if (got !== exp_g[k])
        $display("FAIL contention_grant%0d: got requester %0d expected %0d", k, got, exp_g[k]);
      else n_pass++;
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp_out;
    logic        exp_eq;
    a = $urandom;
    b = $urandom;
    exp_out = a - b;
    exp_eq  = (a == b);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_ctrl = 3'd1;
    #1;
    n_total++;
    if (bus.req0_ready !== 1'b1)
      $display("FAIL bp_accept: got req0_ready=%b expected 1", bus.req0_ready);
    else n_pass++;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd100; bus.req1_op2 = 32'd1; bus.req1_ctrl = 3'd0;
    #1;
    n_total++;
    if (bus.req1_ready !== 1'b0)
      $display("FAIL bp_exec_ready: got req1_ready=%b expected 0", bus.req1_ready);
    else n_pass++;
    bus.resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp_out !== exp_out ||
          bus.resp_eq !== exp_eq || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got v0=%b v1=%b out=%h eq=%b rdy=%b%b expected 1 0 %h %b 00", i,
                 bus.resp0_valid, bus.resp1_valid, bus.resp_out, bus.resp_eq,
                 bus.req0_ready, bus.req1_ready, exp_out, exp_eq);
      else n_pass++;
    end
    bus.resp1_ready = 1'b0;
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1;
    n_total++;
    if (bus.resp0_valid !== 1'b0 || bus.req1_ready !== 1'b1)
      $display("FAIL bp_release: got v0=%b req1_ready=%b expected 0 1", bus.resp0_valid, bus.req1_ready);
    else n_pass++;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (bus.resp1_valid !== 1'b1 || bus.resp_out !== 32'd101)
      $display("FAIL bp_next_resp: got v1=%b out=%0d expected 1 101", bus.resp1_valid, bus.resp_out);
    else n_pass++;
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    bit leaked;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'h1234; bus.req0_op2 = 32'h0F0F; bus.req0_ctrl = 3'd4;
    #1;
    n_total++;
    if (bus.req0_ready !== 1'b1)
      $display("FAIL rx_accept: got req0_ready=%b expected 1", bus.req0_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      $display("FAIL rx_rst_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    n_total++;
    if ({alu_op1, alu_op2, alu_ctrl} !== 67'd0 || bus.resp_out !== 32'd0 || bus.resp_eq !== 1'b0)
      $display("FAIL rx_outputs: got op1=%h op2=%h ctrl=%h out=%h eq=%b expected 0",
               alu_op1, alu_op2, alu_ctrl, bus.resp_out, bus.resp_eq);
    else n_pass++;
    leaked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp0_valid || bus.resp1_valid) leaked = 1'b1;
      @(negedge clk); #1;
    end
    n_total++;
    if (leaked)
      $display("FAIL rx_no_resp: got a response for a dropped op expected none");
    else n_pass++;
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd9; bus.req0_op2 = 32'd2; bus.req0_ctrl = 3'd6;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd1; bus.req1_op2 = 32'd1; bus.req1_ctrl = 3'd0;
    #1;
    n_total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL rx_tie: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    else n_pass++;
    last_op1  = 32'd9;
    last_op2  = 32'd2;
    last_ctrl = 3'd6;
    @(negedge clk);
    idle_inputs();
    @(negedge clk); #1;
    n_total++;
    if (bus.resp0_valid !== 1'b1 || bus.resp_out !== 32'd36)
      $display("FAIL rx_tie_resp: got v0=%b out=%0d expected 1 36", bus.resp0_valid, bus.resp_out);
    else n_pass++;
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_total++;
      if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid} !== 4'b0000 ||
          alu_op1 !== last_op1 || alu_op2 !== last_op2 || alu_ctrl !== last_ctrl)
        $display("FAIL idle%0d: got rdy/vld=%b%b%b%b op1=%h op2=%h ctrl=%h expected 0000 %h %h %h", i,
                 bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid,
                 alu_op1, alu_op2, alu_ctrl, last_op1, last_op2, last_ctrl);
      else n_pass++;
    end
  endtask

  // Transaction-level model: a pending op per requester, one op in flight,
  // response visible from the second cycle after acceptance.
  task automatic test_random();
    bit          p0, p1, busy, mw, mlast, e0, e1, ev0, ev1;
    int          age;
    logic [31:0] a0, b0, a1, b1, mres;
    logic [2:0]  c0, c1;
    logic        meq;
    p0 = 0; p1 = 0; busy = 0; mw = 0; mlast = 1'b1; age = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; c0 = 0; c1 = 0; mres = 0; meq = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom; c0 = 3'($urandom_range(0, 7));
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom; c1 = 3'($urandom_range(0, 7));
      end
      bus.req0_valid = p0; bus.req0_op1 = a0; bus.req0_op2 = b0; bus.req0_ctrl = c0;
      bus.req1_valid = p1; bus.req1_op1 = a1; bus.req1_op2 = b1; bus.req1_ctrl = c1;
      bus.resp0_ready = 1'($urandom_range(0, 1));
      bus.resp1_ready = 1'($urandom_range(0, 1));
      #1;
      e0 = 0; e1 = 0;
      if (!busy && (p0 || p1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (p0) e0 = 1; else e1 = 1;
`else
        if (p0 && p1) begin
          if (mlast) e0 = 1; else e1 = 1;
        end else if (p0) e0 = 1;
        else e1 = 1;
`endif
      end
      ev0 = busy && age >= 2 && !mw;
      ev1 = busy && age >= 2 && mw;
      n_total++;
      if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid} !== {e0, e1, ev0, ev1})
        $display("FAIL rand_hs cyc%0d: got rdy/vld=%b%b%b%b expected %b%b%b%b", cyc,
                 bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, e0, e1, ev0, ev1);
      else n_pass++;
      if (ev0 || ev1) begin
        n_total++;
        if (bus.resp_out !== mres || bus.resp_eq !== meq)
          $display("FAIL rand_resp cyc%0d: got out=%h eq=%b expected %h %b", cyc,
                   bus.resp_out, bus.resp_eq, mres, meq);
        else n_pass++;
      end
      if (busy) begin
        if (age >= 2 && (mw ? bus.resp1_ready : bus.resp0_ready)) busy = 0;
        else age++;
      end else if (e0 || e1) begin
        busy = 1; age = 1; mw = e1; mlast = e1;
        mres = e1 ? alu_ref(a1, b1, c1) : alu_ref(a0, b0, c0);
        meq  = e1 ? (a1 == b1) : (a0 == b0);
        if (e1) p1 = 0; else p0 = 0;
      end
    end
    @(negedge clk);
    idle_inputs();
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    repeat (4) @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    last_op1  = '0;
    last_op2  = '0;
    last_ctrl = '0;
    test_reset();
    test_single();
    test_equality();
    test_contention();
    test_backpressure();
    test_reset_exec();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
